// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - NUM_CH-channel timer: prescaler, compare match, atomic count/compare bus access
// Input capture per channel is built only when TIMER_CAPTURE_EN is defined.
module multi_timer #(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 32,
  parameter  int PRESC_W = 8,
  localparam int CH_W    = $clog2(NUM_CH),
  localparam int AW      = CH_W + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  input  logic              read,
  input  logic              write,
  input  logic              cs,
  output logic [NUM_CH-1:0] irq,
`ifdef TIMER_CAPTURE_EN
  input  logic [NUM_CH-1:0] cap_in,
`endif
  output logic              interrupt
);

  localparam int NB = CNT_W / 8;

  logic [3:0]        w_off;
  logic              w_wr;
  logic              w_rd;
  logic [NUM_CH-1:0] w_sel;
  logic [7:0]        w_ch_rdata [NUM_CH];

  assign w_off = addr[3:0];
  assign w_wr  = cs & write;
  assign w_rd  = cs & read;

  generate
    if (CH_W == 0) begin : g_one
      assign w_sel = 1'b1;
    end else begin : g_many
      for (genvar c = 0; c < NUM_CH; c++) begin : g_dec
        assign w_sel[c] = (addr[AW-1:4] == CH_W'(c));
      end
    end
  endgenerate

  // Indices >= NUM_CH select no channel, so they read 0 and ignore writes.
  always_comb begin
    data_out = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_sel[c]) data_out = data_out | w_ch_rdata[c];
    end
  end

  assign interrupt = |irq;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic               r_en, r_mode, r_inten, r_match, r_missed, r_cap;
    logic [PRESC_W-1:0] r_presc, r_presc_cnt;
    logic [CNT_W-1:0]   r_count, r_cmp, r_stage, r_shadow;
    logic               w_tick, w_hit, w_cap_evt, w_bvalid, w_is_top;
    logic               w_wr_ctrl, w_wr_stat, w_wr_presc, w_wr_cnt, w_wr_stage, w_wr_commit, w_rd_cnt0;
    logic [CNT_W-1:0]   w_cnt_wval, w_stage_wval, w_cmp_wval, w_capture;
    logic [7:0]         w_rdata;

    assign w_tick = r_en & (r_presc_cnt == r_presc);
    assign w_hit  = w_tick & (r_count == r_cmp);

    assign w_bvalid    = int'(w_off[1:0]) < NB;
    assign w_is_top    = int'(w_off[1:0]) == NB - 1;
    assign w_wr_ctrl   = w_wr & w_sel[c] & (w_off == 4'd0);
    assign w_wr_stat   = w_wr & w_sel[c] & (w_off == 4'd1);
    assign w_wr_presc  = w_wr & w_sel[c] & (w_off == 4'd2);
    assign w_wr_cnt    = w_wr & w_sel[c] & (w_off[3:2] == 2'd1) & w_bvalid;
    assign w_wr_stage  = w_wr & w_sel[c] & (w_off[3:2] == 2'd2) & w_bvalid & ~w_is_top;
    assign w_wr_commit = w_wr & w_sel[c] & (w_off[3:2] == 2'd2) & w_is_top;
    assign w_rd_cnt0   = w_rd & w_sel[c] & (w_off == 4'd4);

    always_comb begin
      w_cnt_wval   = r_count;
      w_stage_wval = r_stage;
      for (int b = 0; b < NB; b++) begin
        if (int'(w_off[1:0]) == b) begin
          w_cnt_wval[8*b +: 8]   = data_in;
          w_stage_wval[8*b +: 8] = data_in;
        end
      end
      w_cmp_wval = r_stage;
      w_cmp_wval[CNT_W-1 -: 8] = data_in;
    end

`ifdef TIMER_CAPTURE_EN
    logic [2:0]       r_cap_sync;
    logic [CNT_W-1:0] r_capture;

    // Two synchroniser flops plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cap_sync <= '0;
        r_capture  <= '0;
      end else begin
        r_cap_sync <= {r_cap_sync[1:0], cap_in[c]};
        if (w_cap_evt) r_capture <= r_count;
      end
    end
    assign w_cap_evt = r_cap_sync[1] & ~r_cap_sync[2];
    assign w_capture = r_capture;
`else
    assign w_cap_evt = 1'b0;
    assign w_capture = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_en        <= 1'b0;
        r_mode      <= 1'b0;
        r_inten     <= 1'b0;
        r_match     <= 1'b0;
        r_missed    <= 1'b0;
        r_cap       <= 1'b0;
        r_presc     <= '0;
        r_presc_cnt <= '0;
        r_count     <= '0;
        r_cmp       <= '1;
        r_stage     <= '0;
        r_shadow    <= '0;
      end else begin
        if (r_en) r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_W'(1);
        if (w_tick) begin
          if (w_hit) begin
            if (r_mode) r_count <= '0;
            else        r_en    <= 1'b0;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        if (w_wr_stat) begin
          if (data_in[0]) r_match  <= 1'b0;
          if (data_in[2]) r_missed <= 1'b0;
          if (data_in[3]) r_cap    <= 1'b0;
        end
        // Hardware events come after the W1C so a same-cycle set wins.
        if (w_hit) begin
          r_match <= 1'b1;
          if (r_match) r_missed <= 1'b1;
        end
        if (w_cap_evt) begin
          r_cap <= 1'b1;
          if (r_cap) r_missed <= 1'b1;
        end
        if (w_wr_cnt)    r_count  <= w_cnt_wval;
        if (w_wr_presc)  r_presc  <= data_in[PRESC_W-1:0];
        if (w_wr_stage)  r_stage  <= w_stage_wval;
        if (w_wr_commit) r_cmp    <= w_cmp_wval;
        if (w_rd_cnt0)   r_shadow <= r_count;
        if (w_wr_ctrl) begin
          r_en    <= data_in[0];
          r_mode  <= data_in[1];
          r_inten <= data_in[2];
          if (data_in[3]) begin
            r_count     <= '0;
            r_presc_cnt <= '0;
            r_match     <= 1'b0;
            r_missed    <= 1'b0;
          end
        end
      end
    end

    always_comb begin
      w_rdata = 8'h00;
      for (int b = 0; b < NB; b++) begin
        if (int'(w_off[1:0]) == b) begin
          case (w_off[3:2])
            2'd1:    w_rdata = (b == 0) ? r_count[7:0] : r_shadow[8*b +: 8];
            2'd2:    w_rdata = r_cmp[8*b +: 8];
            2'd3:    w_rdata = w_capture[8*b +: 8];
            default: w_rdata = 8'h00;
          endcase
        end
      end
      if (w_off == 4'd0)      w_rdata = {5'b0, r_inten, r_mode, r_en};
      else if (w_off == 4'd1) w_rdata = {4'b0, r_cap, r_missed, r_en, r_match};
      else if (w_off == 4'd2) w_rdata = 8'(r_presc);
    end

    assign w_ch_rdata[c] = w_rdata;
    assign irq[c]        = r_inten & (r_match | r_cap);
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Parametrised multi-channel successor to the single system timer. It provides NUM_CH independent timer channels, each with a CNT_W-bit up-counter, a per-channel prescaler, compare match, and one-shot or continuous mode. Multi-byte counters read atomically through a snapshot, and compare values commit atomically through a staging register. It sits on the 8-bit I/O bus and drives a per-channel IRQ vector plus a combined interrupt for the scheduler tick and OS timers.

Parameters:
NUM_CH, 4, number of channels; legal values 1..8
CNT_W, 32, counter/compare width; legal values 8, 16, 24, 32
PRESC_W, 8, prescaler width; legal values 1..8

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
addr  input  $clog2(NUM_CH)+4 (min 4)  [MSBs] = channel index, [3:0] = register offset
data_in  input  8  write data
data_out  output  8  read data, combinational from addr
read  input  1  read strobe, qualified by cs
write  input  1  write strobe, qualified by cs
cs  input  1  chip select
irq  output  NUM_CH  per-channel interrupt
interrupt  output  1  OR of irq
cap_in  input  NUM_CH  capture inputs; present only with TIMER_CAPTURE_EN

Behaviour:
- Reset: all registers, counters, prescaler counts, shadows and staging are 0, except compare = all-ones. irq = 0, interrupt = 0.
- Register offsets per channel:
  - 0 CTRL: b0 ENABLE, b1 MODE (1 = continuous), b2 INT_EN, b3 RESET.
  - 1 STATUS: b0 MATCH (W1C), b1 RUNNING (read-only, equals ENABLE), b2 MISSED (W1C), b3 CAP (W1C).
  - 2 PRESCALE.
  - 4..7 COUNT bytes 0..3.
  - 8..11 COMPARE bytes 0..3.
  - 12..15 CAPTURE bytes 0..3 (only with the macro).
  - Unused bits, bytes at or above CNT_W/8, offset 3, and channel index >= NUM_CH: read 0, writes ignored.
- Prescaler:
  - presc_cnt runs only while ENABLE = 1.
  - tick when presc_cnt == PRESCALE; presc_cnt then returns to 0, else it increments.
- Counting, on each tick:
  - If count == compare: match event. Set MATCH; if MATCH was already 1, also set MISSED.
  - On a match event in continuous mode: count <= 0. In one-shot mode: ENABLE <= 0 and count holds.
  - Otherwise: count <= count + 1, wrapping modulo 2^CNT_W with no event.
  - Period in continuous mode = (compare+1)*(PRESCALE+1) clocks.
- CTRL.RESET: self-clearing; always reads 0. A write with b3 = 1 clears count, presc_cnt, MATCH and MISSED in that cycle. Other CTRL bits take the written value.
- COUNT read: a read (cs & read) of byte 0 returns live byte 0 and latches the whole count into a shadow on that edge. Bytes 1..3 read from the shadow.
- COUNT write: the written byte goes directly into the live counter.
- COMPARE write: bytes go to staging. Writing the top byte (CNT_W/8 - 1) commits staging plus the top byte to compare in one cycle. COMPARE reads return the committed value.
- irq[ch] = INT_EN & (MATCH | CAP). interrupt = |irq. Both are combinational from registers.
- Same-cycle conflicts:
  - Hardware set beats W1C clear for the same bit.
  - CPU write to COUNT beats a tick increment or reload.
  - CPU write to CTRL beats one-shot auto-disable.
  - Channels are fully independent.

Optional Feature:
TIMER_CAPTURE_EN
- Defined: cap_in[ch] passes through a 2-flop synchroniser. A rising edge on the synchronised signal latches count into CAPTURE and sets CAP; if CAP was already 1, MISSED is also set. Capture is active even when ENABLE = 0.
- Undefined: no cap_in port, CAPTURE reads 0, CAP is always 0.

Test Plan:
1. ch0: PRESCALE = 0, compare = 4, CTRL = 0x07 -> MATCH on the 5th tick after enable, count reloads to 0, irq[0] = 1 every 5 clocks; W1C on STATUS with 0x01 clears it. Leave MATCH uncleared across a second match -> MISSED = 1.
2. ch2: PRESCALE = 3, compare = 2, CTRL = 0x05 (one-shot) -> MATCH after 12 clocks, ENABLE = 0, RUNNING = 0, count holds at 2; ch0/ch1 unaffected.
3. Count at 0x000000FF incrementing -> read byte 0 returns 0xFF, the next cycle's tick makes it 0x100, and bytes 1..3 read 0x00 from the shadow (atomic value).
4. Write COMPARE bytes 0..2 = 0x10 while running -> old compare still matches; write byte 3 = 0 -> compare becomes 0x00101010 in that cycle.
5. W1C on STATUS in the same cycle as a match event -> MATCH stays 1. Write CTRL = 0x0D -> count = 0, MATCH = 0, CTRL reads 0x05.
6. With TIMER_CAPTURE_EN: pulse cap_in[1] while count = 0x20 -> CAPTURE holds 0x22 (2-cycle synchroniser delay at PRESCALE = 0), CAP = 1, irq[1] = 1 when INT_EN = 1.
